// File: rtl/exe_mem_stage_buf.sv
// EXE-to-MEM stage buffer: elastic valid/ready with a 2-entry skid, flush, and forwarding tap.
// Optional statistics counters are built when EXE_MEM_STATS_EN is defined.
module exe_mem_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_address,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_flush_cnt
);

  // Payload layout, LSB first: dest, st_val, alu_result, mem_w_en, mem_r_en, wb_en.
  localparam int PW      = 3 + 2 * DATA_W + DEST_W;
  localparam int ST_LSB  = DEST_W;
  localparam int ALU_LSB = DEST_W + DATA_W;
  localparam int W_BIT   = DEST_W + 2 * DATA_W;
  localparam int R_BIT   = W_BIT + 1;
  localparam int WB_BIT  = W_BIT + 2;

  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic          accept;

  assign in_pl    = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_result, in_st_val, in_dest};
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  // Main refills from skid first so ordering stays FIFO; skid only fills behind a stalled main.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_pl;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_pl;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_wb_en    = main_valid_q & main_q[WB_BIT];
  assign out_mem_r_en = main_valid_q & main_q[R_BIT];
  assign out_mem_w_en = main_valid_q & main_q[W_BIT];
  assign out_address  = main_q[ALU_LSB +: DATA_W];
  assign out_data     = main_q[ST_LSB +: DATA_W];
  assign out_dest     = main_q[DEST_W-1:0];

  // Loads are not forwardable from here: their value only exists after the memory read.
  assign fwd_valid = out_valid & out_wb_en & ~out_mem_r_en;
  assign fwd_dest  = out_dest;
  assign fwd_value = out_address;

`ifdef EXE_MEM_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters; only rst clears them, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      if (flush && (main_valid_q || skid_valid_q) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + STAT_W'(1);
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`else
  assign stat_stall_cnt = '0;
  assign stat_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_mem_stage_buf.sv
// Self-checking bench for exe_mem_stage_buf; reference model is a 2-deep FIFO queue.
// Honours EXE_MEM_STATS_EN for the expected counter values.
module tb_exe_mem_stage_buf;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int STAT_W = 4;
  localparam int SMAX   = (1 << STAT_W) - 1;

  typedef struct packed {
    logic              wb;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [DEST_W-1:0] dest;
  } ent_t;

  logic              clk, rst, flush, inValid, inReady, outReady;
  logic              inWbEn, inMemREn, inMemWEn;
  logic [DATA_W-1:0] inAlu, inSt;
  logic [DEST_W-1:0] inDest;
  logic              outValid, outWbEn, outMemREn, outMemWEn, fwdValid;
  logic [DATA_W-1:0] outAddress, outData, fwdValue;
  logic [DEST_W-1:0] outDest, fwdDest;
  logic [STAT_W-1:0] statStall, statFlush;

  int   nCompared   = 0;
  int   nMismatched = 0;
  ent_t mq[$];
  int   mStall = 0;
  int   mFlush = 0;

  exe_mem_stage_buf #(.DATA_W(DATA_W), .DEST_W(DEST_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady),
    .in_wb_en(inWbEn), .in_mem_r_en(inMemREn), .in_mem_w_en(inMemWEn),
    .in_alu_result(inAlu), .in_st_val(inSt), .in_dest(inDest),
    .out_valid(outValid), .out_ready(outReady),
    .out_wb_en(outWbEn), .out_mem_r_en(outMemREn), .out_mem_w_en(outMemWEn),
    .out_address(outAddress), .out_data(outData), .out_dest(outDest),
    .fwd_valid(fwdValid), .fwd_dest(fwdDest), .fwd_value(fwdValue),
    .stat_stall_cnt(statStall), .stat_flush_cnt(statFlush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input bit v, input ent_t e, input bit ordy, input bit fl);
    inValid  = v;
    inWbEn   = e.wb;
    inMemREn = e.rd;
    inMemWEn = e.wr;
    inAlu    = e.alu;
    inSt     = e.st;
    inDest   = e.dest;
    outReady = ordy;
    flush    = fl;
  endtask

  function automatic ent_t mk(input logic [DATA_W-1:0] alu, input logic [DEST_W-1:0] dest);
    ent_t e;
    e.wb = 1'b1; e.rd = 1'b0; e.wr = 1'b0;
    e.alu = alu; e.st = alu ^ 32'h5A5A_0000; e.dest = dest;
    return e;
  endfunction

  // Advance the model by the rules, then clock the DUT; returns #1 after the edge.
  task automatic tick();
    bit acc;
    ent_t e;
    e = '{wb: inWbEn, rd: inMemREn, wr: inMemWEn, alu: inAlu, st: inSt, dest: inDest};
    if (mq.size() > 0 && !outReady && mStall < SMAX) mStall++;
    if (flush && mq.size() > 0 && mFlush < SMAX) mFlush++;
    if (flush) mq.delete();
    else begin
      acc = inValid && (mq.size() < 2);
      if (mq.size() > 0 && outReady) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mq.delete();
    mStall = 0;
    mFlush = 0;
  endtask

  function automatic int expStall();
`ifdef EXE_MEM_STATS_EN
    return mStall;
`else
    return 0;
`endif
  endfunction

  function automatic int expFlush();
`ifdef EXE_MEM_STATS_EN
    return mFlush;
`else
    return 0;
`endif
  endfunction

  task automatic test_reset();
    applyStimulus(1'b1, mk(32'h1111, 4'd1), 1'b0, 1'b0); tick();
    applyStimulus(1'b1, mk(32'h2222, 4'd2), 1'b0, 1'b0); tick();
    nCompared++;
    if (inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_prefill in_ready got %b want 0", inReady); end
    rst = 1'b1;
    #2;
    nCompared++;
    if ({outValid, inReady, outWbEn, fwdValid} !== 4'b0100) begin
      nMismatched++; $display("[TB] FAIL reset_flags got v=%b r=%b wb=%b fwd=%b want 0 1 0 0", outValid, inReady, outWbEn, fwdValid);
    end
    nCompared++;
    if (outAddress !== '0 || outData !== '0 || outDest !== '0) begin
      nMismatched++; $display("[TB] FAIL reset_payload got addr=%h data=%h dest=%h want 0", outAddress, outData, outDest);
    end
    nCompared++;
    if (statStall !== '0 || statFlush !== '0) begin
      nMismatched++; $display("[TB] FAIL reset_stats got %0d/%0d want 0/0", statStall, statFlush);
    end
    doReset();
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] vals[3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mk(vals[i], 4'(i + 1)), 1'b1, 1'b0);
      tick();
      nCompared++;
      if (outValid !== 1'b1 || outAddress !== vals[i] || inReady !== 1'b1) begin
        nMismatched++; $display("[TB] FAIL stream_%0d got v=%b addr=%h rdy=%b want 1 %h 1", i, outValid, outAddress, inReady, vals[i]);
      end
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    nCompared++;
    if (outValid !== 1'b0 || outWbEn !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL stream_drain got v=%b wb=%b want 0 0", outValid, outWbEn);
    end
  endtask

  task automatic test_stall_skid();
    doReset();
    applyStimulus(1'b1, mk(32'h100, 4'd3), 1'b0, 1'b0); tick();
    applyStimulus(1'b1, mk(32'h200, 4'd4), 1'b0, 1'b0); tick();
    nCompared++;
    if (inReady !== 1'b0 || outAddress !== 32'h100 || outValid !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL skid_full got rdy=%b addr=%h v=%b want 0 100 1", inReady, outAddress, outValid);
    end
    applyStimulus(1'b1, mk(32'h999, 4'd9), 1'b0, 1'b0); tick();
    nCompared++;
    if (outAddress !== 32'h100 || inReady !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL skid_hold got addr=%h rdy=%b want 100 0", outAddress, inReady);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0); tick();
    nCompared++;
    if (outValid !== 1'b1 || outAddress !== 32'h200 || outDest !== 4'd4 || inReady !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL skid_second got v=%b addr=%h dest=%0d rdy=%b want 1 200 4 1", outValid, outAddress, outDest, inReady);
    end
    tick();
    nCompared++;
    if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL skid_empty got v=%b want 0", outValid); end
  endtask

  task automatic test_flush();
    doReset();
    applyStimulus(1'b1, mk(32'hA1, 4'd1), 1'b0, 1'b0); tick();
    applyStimulus(1'b1, mk(32'hB2, 4'd2), 1'b0, 1'b0); tick();
    applyStimulus(1'b1, mk(32'h300, 4'd7), 1'b1, 1'b1); tick();
    nCompared++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || outWbEn !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL flush_clear got v=%b rdy=%b wb=%b want 0 1 0", outValid, inReady, outWbEn);
    end
    nCompared++;
    if (int'(statFlush) !== expFlush()) begin
      nMismatched++; $display("[TB] FAIL flush_count got %0d want %0d", statFlush, expFlush());
    end
    // Flush with room available still drops the presented input.
    applyStimulus(1'b1, mk(32'h300, 4'd7), 1'b1, 1'b1); tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++;
      if (outValid !== 1'b0) begin
        nMismatched++; $display("[TB] FAIL flush_dropped_%0d got v=%b addr=%h want v=0", i, outValid, outAddress);
      end
    end
  endtask

  task automatic test_forwarding();
    ent_t e;
    doReset();
    e = mk(32'hABCD, 4'd5);
    applyStimulus(1'b1, e, 1'b0, 1'b0); tick();
    nCompared++;
    if (fwdValid !== 1'b1 || fwdDest !== 4'd5 || fwdValue !== 32'hABCD) begin
      nMismatched++; $display("[TB] FAIL fwd_alu got v=%b dest=%0d val=%h want 1 5 abcd", fwdValid, fwdDest, fwdValue);
    end
    e.rd = 1'b1;
    applyStimulus(1'b1, e, 1'b1, 1'b0); tick();
    nCompared++;
    if (fwdValid !== 1'b0 || outMemREn !== 1'b1 || fwdDest !== 4'd5) begin
      nMismatched++; $display("[TB] FAIL fwd_load got v=%b r=%b dest=%0d want 0 1 5", fwdValid, outMemREn, fwdDest);
    end
    e.wr = 1'b1;
    applyStimulus(1'b1, e, 1'b1, 1'b0); tick();
    nCompared++;
    if (outMemREn !== 1'b1 || outMemWEn !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL both_en got r=%b w=%b want 1 1", outMemREn, outMemWEn);
    end
  endtask

  task automatic test_stats_saturation();
    doReset();
    applyStimulus(1'b1, mk(32'h55, 4'd6), 1'b0, 1'b0); tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    nCompared++;
`ifdef EXE_MEM_STATS_EN
    if (statStall !== 4'd15) begin nMismatched++; $display("[TB] FAIL stall_sat got %0d want 15", statStall); end
`else
    if (statStall !== 4'd0) begin nMismatched++; $display("[TB] FAIL stall_sat got %0d want 0", statStall); end
`endif
    nCompared++;
    if (outValid !== 1'b1 || outAddress !== 32'h55) begin
      nMismatched++; $display("[TB] FAIL stall_hold got v=%b addr=%h want 1 55", outValid, outAddress);
    end
  endtask

  task automatic test_random();
    ent_t e, x;
    bit   ev;
    doReset();
    for (int c = 0; c < 400; c++) begin
      e.wb = 1'($urandom); e.rd = 1'($urandom); e.wr = 1'($urandom);
      e.alu = $urandom; e.st = $urandom; e.dest = 4'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 19) == 0));
      tick();
      ev = (mq.size() > 0);
      x  = ev ? mq[0] : '0;
      nCompared++;
      if (outValid !== ev || inReady !== (mq.size() < 2)) begin
        nMismatched++; $display("[TB] FAIL rand_flow c=%0d got v=%b rdy=%b want %b %b", c, outValid, inReady, ev, mq.size() < 2);
      end
      nCompared++;
      if ({outWbEn, outMemREn, outMemWEn} !== {x.wb, x.rd, x.wr} || fwdValid !== (x.wb & ~x.rd)) begin
        nMismatched++; $display("[TB] FAIL rand_ctrl c=%0d got %b%b%b fwd=%b want %b%b%b", c, outWbEn, outMemREn, outMemWEn, fwdValid, x.wb, x.rd, x.wr);
      end
      if (ev) begin
        nCompared++;
        if (outAddress !== x.alu || outData !== x.st || outDest !== x.dest || fwdValue !== x.alu || fwdDest !== x.dest) begin
          nMismatched++; $display("[TB] FAIL rand_data c=%0d got %h/%h/%0d want %h/%h/%0d", c, outAddress, outData, outDest, x.alu, x.st, x.dest);
        end
      end
      nCompared++;
      if (int'(statStall) !== expStall() || int'(statFlush) !== expFlush()) begin
        nMismatched++; $display("[TB] FAIL rand_stats c=%0d got %0d/%0d want %0d/%0d", c, statStall, statFlush, expStall(), expFlush());
      end
    end
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_forwarding();
    test_stats_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
